// File: rtl/obj_tile_compositor_pkg.sv
// Object table field layout, tile grid geometry and ROM address packing.
// Shared with the game controller, which writes the object RAM.
package obj_tile_compositor_pkg;

  localparam int N_OBJ      = 8;
  localparam int IDX_W      = $clog2(N_OBJ);
  localparam int TILE_SHIFT = 5;
  localparam int X_OFFSET   = 16;
  localparam int GRID_W     = 19;
  localparam int GRID_H     = 15;

  localparam int OBJ_ON     = 12;
  localparam int OBJ_TILE_L = 9;
  localparam int OBJ_X_L    = 4;
  localparam int OBJ_Y_L    = 0;

  typedef struct packed {
    logic       on;
    logic [2:0] tile;
    logic [4:0] x;
    logic [3:0] y;
  } obj_t;

  typedef struct packed {
    logic [2:0] tile;
    logic [4:0] py;
    logic [4:0] px;
  } rom_addr_t;

  typedef struct packed {
    logic       v;
    logic       de;
    logic [4:0] tx;
    logic [3:0] ty;
    logic [4:0] px;
    logic [4:0] py;
  } s1_t;

  typedef struct packed {
    logic       hit;
    logic       de;
    logic [2:0] tile;
    logic [4:0] px;
    logic [4:0] py;
  } s2_t;

  function automatic rom_addr_t romAddr(
    input logic [2:0] tile,
    input logic [4:0] py,
    input logic [4:0] px
  );
    romAddr = '{tile: tile, py: py, px: px};
  endfunction

endpackage

// File: rtl/obj_tile_compositor_if.sv
// Object RAM write port driven by the game controller.
// One slot is written per strobed cycle.
interface obj_tile_compositor_if;
  import obj_tile_compositor_pkg::*;

  logic             we;
  logic [IDX_W-1:0] addr;
  obj_t             data;

  modport master (output we, addr, data);
  modport slave  (input  we, addr, data);

endinterface

// File: rtl/obj_priority_match.sv
// Fixed-priority pick over the object match vector.
// Lowest slot index wins.
module obj_priority_match
  import obj_tile_compositor_pkg::*;
(
  input  logic [N_OBJ-1:0] match,
  output logic             hit,
  output logic [IDX_W-1:0] idx
);

  always_comb begin
    hit = |match;
    idx = '0;
    for (int i = N_OBJ - 1; i >= 0; i--) begin
      if (match[i]) idx = IDX_W'(i);
    end
  end

endmodule

// File: rtl/obj_tile_compositor.sv
// Double-buffered object table and 3-stage per-pixel tile hit pipeline.
// Shadow is copied to active on each VS falling edge.
module obj_tile_compositor
  import obj_tile_compositor_pkg::*;
(
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  iVS,
  obj_tile_compositor_if.slave  objRam,
  input  logic [9:0]            iPixX,
  input  logic [9:0]            iPixY,
  input  logic                  iDE,
  output logic                  oHit,
  output logic [2:0]            oTile,
  output logic [12:0]           oRomAddr,
  output logic                  oDE
);

  obj_t shadow [N_OBJ];
  obj_t active [N_OBJ];
  logic lastVS;
  logic frameSyn;

  assign frameSyn = lastVS & ~iVS;

  // Swap copies the pre-write shadow; a same-cycle write waits a frame.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      lastVS <= 1'b0;
      for (int i = 0; i < N_OBJ; i++) begin
        shadow[i] <= '0;
        active[i] <= '0;
      end
    end else begin
      lastVS <= iVS;
      if (frameSyn) begin
        for (int i = 0; i < N_OBJ; i++)
          active[i] <= shadow[i];
      end
      if (objRam.we)
        shadow[objRam.addr] <= objRam.data;
    end
  end

  logic [10:0] rx;
  logic        inX;
  logic        inY;
  s1_t         s1;

  assign rx  = {1'b0, iPixX} - 11'(X_OFFSET);
  assign inX = !rx[10] && (rx[9:5] < 5'(GRID_W));
  assign inY = iPixY < 10'(GRID_H << TILE_SHIFT);

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      s1 <= '0;
    end else begin
      s1.v  <= iDE & inX & inY;
      s1.de <= iDE;
      s1.tx <= rx[9:5];
      s1.px <= rx[4:0];
      s1.ty <= iPixY[8:5];
      s1.py <= iPixY[4:0];
    end
  end

  logic [N_OBJ-1:0] match;
  logic             anyHit;
  logic [IDX_W-1:0] win;
  s2_t              s2;

  always_comb begin
    match = '0;
    for (int i = 0; i < N_OBJ; i++) begin
      match[i] = active[i].on
              && active[i].x == s1.tx
              && active[i].y == s1.ty;
    end
  end

  obj_priority_match u_match (
    .match (match),
    .hit   (anyHit),
    .idx   (win)
  );

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      s2 <= '0;
    end else begin
      s2.hit  <= s1.v & anyHit;
      s2.de   <= s1.de;
      s2.tile <= active[win].tile;
      s2.px   <= s1.px;
      s2.py   <= s1.py;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      oHit     <= 1'b0;
      oTile    <= '0;
      oRomAddr <= '0;
      oDE      <= 1'b0;
    end else begin
      oHit     <= s2.hit;
      oTile    <= s2.hit ? s2.tile : 3'd0;
      oRomAddr <= s2.hit
                ? romAddr(s2.tile, s2.py, s2.px)
                : 13'd0;
      oDE      <= s2.de;
    end
  end

endmodule

// File: tb/tb_obj_tile_compositor.sv
// Randomised and directed bench for obj_tile_compositor.
// Reference computes hits from pixel coordinates with plain arithmetic.
module tb_obj_tile_compositor;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        iVS = 1'b0;
  logic [9:0]  iPixX = '0;
  logic [9:0]  iPixY = '0;
  logic        iDE = 1'b0;
  logic        oHit;
  logic [2:0]  oTile;
  logic [12:0] oRomAddr;
  logic        oDE;

  obj_tile_compositor_if objRam ();

  obj_tile_compositor dut (
    .clk      (clk),
    .reset_n  (reset_n),
    .iVS      (iVS),
    .objRam   (objRam.slave),
    .iPixX    (iPixX),
    .iPixY    (iPixY),
    .iDE      (iDE),
    .oHit     (oHit),
    .oTile    (oTile),
    .oRomAddr (oRomAddr),
    .oDE      (oDE)
  );

  always #5 clk = ~clk;

  typedef struct {
    bit de;
    int x;
    int y;
  } pix_t;

  int          nCmp = 0;
  int          nFail = 0;
  logic [12:0] mShadow [8];
  logic [12:0] mActive [8];
  bit          mLastVS = 0;
  pix_t        prevPix = '{0, 0, 0};
  logic [17:0] expNext = '0;
  logic [17:0] expOut = '0;

  task automatic check(input string tag,
                       input logic [17:0] obs,
                       input logic [17:0] exp);
    nCmp++;
    assert (obs === exp) else begin
      nFail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Expected {hit, tile, romAddr, de} for one pixel against mActive.
  function automatic logic [17:0] refPix(input pix_t p);
    logic        hit = 0;
    logic [2:0]  tile = 0;
    logic [12:0] rom = 0;
    int tx, ty, ox, oy;
    if (p.de && p.x >= 16 && p.x < 16 + 19 * 32 && p.y < 15 * 32) begin
      tx = (p.x - 16) / 32;
      ty = p.y / 32;
      for (int i = 0; i < 8; i++) begin
        ox = int'(mActive[i][8:4]);
        oy = int'(mActive[i][3:0]);
        if (!hit && mActive[i][12] && ox == tx && oy == ty) begin
          hit  = 1;
          tile = mActive[i][11:9];
          rom  = 13'(int'(tile) * 1024 + (p.y % 32) * 32
                     + (p.x - 16) % 32);
        end
      end
    end
    return {hit, tile, rom, p.de};
  endfunction

  task automatic step(input bit rst, input int x, input int y,
                      input bit de, input bit vs, input bit we,
                      input int a, input logic [12:0] d);
    reset_n     = !rst;
    iPixX       = 10'(x);
    iPixY       = 10'(y);
    iDE         = de;
    iVS         = vs;
    objRam.we   = we;
    objRam.addr = 3'(a);
    objRam.data = d;
    @(posedge clk);
    if (rst) begin
      for (int i = 0; i < 8; i++) begin
        mShadow[i] = '0;
        mActive[i] = '0;
      end
      mLastVS = 0;
      prevPix = '{0, 0, 0};
      expNext = '0;
      expOut  = '0;
    end else begin
      expOut  = expNext;
      expNext = refPix(prevPix);
      if (mLastVS && !vs)
        for (int i = 0; i < 8; i++) mActive[i] = mShadow[i];
      if (we) mShadow[a] = d;
      mLastVS = vs;
      prevPix = '{de, x, y};
    end
    #1;
    check("pipe", {oHit, oTile, oRomAddr, oDE}, expOut);
  endtask

  task automatic idle();
    step(0, 0, 0, 0, 0, 0, 0, '0);
  endtask

  task automatic wr(input int a, input logic [12:0] d);
    step(0, 0, 0, 0, 0, 1, a, d);
  endtask

  task automatic swap();
    step(0, 0, 0, 0, 1, 0, 0, '0);
    idle();
  endtask

  task automatic probe(input string tag, input int x, input int y,
                       input logic expHit, input logic [2:0] expTile,
                       input logic [12:0] expRom);
    step(0, x, y, 1, 0, 0, 0, '0);
    idle();
    idle();
    check(tag, {oHit, oTile, oRomAddr, oDE},
          {expHit, expTile, expRom, 1'b1});
  endtask

  initial begin
    step(1, 0, 0, 0, 0, 0, 0, '0);
    step(1, 0, 0, 0, 0, 0, 0, '0);
    check("reset", {oHit, oTile, oRomAddr, oDE}, 18'h0);

    for (int y = 0; y < 480; y += 8)
      for (int x = 0; x < 640; x += 5)
        step(0, x, y, 1, 0, 0, 0, '0);
    idle();
    idle();

    wr(0, 13'h1011);
    swap();
    probe("s0_hit", 48, 32, 1, 3'd0, 13'h000);
    probe("s0_corner", 79, 63, 1, 3'd0, 13'h3FF);
    probe("s0_left", 47, 32, 0, 3'd0, 13'h000);

    wr(0, 13'h1021);
    probe("no_swap_old", 48, 32, 1, 3'd0, 13'h000);
    probe("no_swap_new", 80, 32, 0, 3'd0, 13'h000);
    swap();
    probe("swap_new", 80, 32, 1, 3'd0, 13'h000);
    probe("swap_old", 48, 32, 0, 3'd0, 13'h000);

    wr(1, 13'h131D);
    wr(3, 13'h1B1D);
    swap();
    probe("prio_s1", 560, 416, 1, 3'd1, 13'h0400);
    wr(1, 13'h031D);
    swap();
    probe("prio_s3", 560, 416, 1, 3'd5, 13'h1400);

    step(0, 0, 0, 0, 1, 0, 0, '0);
    step(0, 0, 0, 0, 0, 1, 2, 13'h1655);
    probe("syn_wr_hidden", 176, 160, 0, 3'd0, 13'h000);
    swap();
    probe("syn_wr_shown", 176, 160, 1, 3'd3, 13'h0C00);

    for (int i = 0; i < 4; i++) step(0, 176 + i, 160, 1, 0, 0, 0, '0);
    step(1, 180, 160, 1, 0, 0, 0, '0);
    check("rst_mid", {oHit, oTile, oRomAddr, oDE}, 18'h0);
    probe("rst_off", 176, 160, 0, 3'd0, 13'h000);
    swap();
    probe("rst_off_swap", 176, 160, 0, 3'd0, 13'h000);
    wr(2, 13'h1655);
    swap();
    probe("rst_rewrite", 176, 160, 1, 3'd3, 13'h0C00);

    for (int n = 0; n < 4000; n++) begin
      int x, y;
      bit we, vs, de;
      we = ($urandom_range(7) == 0);
      vs = ($urandom_range(150) == 0) || iVS && ($urandom_range(3) != 0);
      de = ($urandom_range(9) != 0);
      if ($urandom_range(1) == 0) begin
        x = $urandom_range(1023);
        y = $urandom_range(1023);
      end else begin
        x = 16 + 32 * $urandom_range(19) + $urandom_range(31);
        y = 32 * $urandom_range(15) + $urandom_range(31);
      end
      step($urandom_range(999) == 0, x, y, de, vs, we,
           $urandom_range(7), 13'($urandom));
    end
    idle();
    idle();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             nCmp, nFail);
    $finish;
  end

endmodule
